// File: rtl/shiftadd_multiplier_seq.sv
`default_nettype none
// ============================================================================
// Module      : shiftadd_multiplier_seq
// Description : Sequential shift-add multiplier with signed mode, zero-operand
//               fast path and start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module shiftadd_multiplier_seq #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   multiplicand,
  input  logic [WIDTH-1:0]   multiplier,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] C_LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t             r_state;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_acc;
  logic               r_neg;
  logic [CNT_W-1:0]   r_cnt;
  logic [2*WIDTH-1:0] r_product;

  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_sum;

  // Magnitude of the most negative value wraps to 2^(WIDTH-1), still exact unsigned.
  assign w_a_mag = (signed_mode && multiplicand[WIDTH-1]) ? (~multiplicand + 1'b1) : multiplicand;
  assign w_b_mag = (signed_mode && multiplier[WIDTH-1])   ? (~multiplier + 1'b1)   : multiplier;
  assign w_sum   = {1'b0, r_acc} + (r_mplr[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_mcand   <= '0;
      r_mplr    <= '0;
      r_acc     <= '0;
      r_neg     <= 1'b0;
      r_cnt     <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_mcand <= w_a_mag;
            r_mplr  <= w_b_mag;
            r_neg   <= signed_mode & (multiplicand[WIDTH-1] ^ multiplier[WIDTH-1]);
            r_acc   <= '0;
            r_cnt   <= '0;
            if (multiplicand == '0 || multiplier == '0) begin
              r_product <= '0;
              r_state   <= S_DONE;
            end else begin
              r_state <= S_CALC;
            end
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_CALC: begin
          r_acc  <= w_sum[WIDTH:1];
          r_mplr <= {w_sum[0], r_mplr[WIDTH-1:1]};
          r_cnt  <= r_cnt + 1'b1;
          if (r_cnt == C_LAST_CNT) begin
            r_state <= S_FIX;
          end
        end
        S_FIX: begin
          r_product <= r_neg ? -{r_acc, r_mplr} : {r_acc, r_mplr};
          r_state   <= S_DONE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy    = (r_state == S_CALC) || (r_state == S_FIX);
  assign done    = (r_state == S_DONE);
  assign product = r_product;

endmodule
`default_nettype wire
